booth_radix4_multiplier: RTL
============================

BOOTH_RADIX4_MULTIPLIER -- requirements
Module: booth_radix4_multiplier

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, operand width; legal values are even and >= 4, and an illegal value is a compile/elaboration error.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL provide port start  input  1  request new multiplication; sampled only in IDLE.
REQ-005 SHALL provide port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned operands; captured with start.
REQ-006 SHALL provide port A  input  WIDTH  multiplier operand; captured with start.
REQ-007 SHALL provide port B  input  WIDTH  multiplicand operand; captured with start.
REQ-008 SHALL provide port prod  output  2*WIDTH  registered product; signed or unsigned per captured signed_mode.
REQ-009 SHALL provide port busy  output  1  high while an operation is in CALC or DONE.
REQ-010 SHALL provide port done  output  1  single-cycle pulse; prod is valid from this cycle onward.

Function
REQ-011 SHALL implement states IDLE, CALC and DONE.
REQ-012 SHALL, when in IDLE and start=1 at a rising edge:
- capture A, B and signed_mode;
- extend each operand to WIDTH+2 bits: sign-extend if signed_mode=1, zero-extend if 0;
- clear the accumulator and the iteration counter;
- go to CALC.
REQ-013 SHALL use radix-4 Booth recoding in CALC, one iteration per cycle, for ITER = WIDTH/2+1 cycles, in both modes.
REQ-014 SHALL, in each iteration, examine 3 bits (multiplier pair plus previous bit, initially 0) and add the following to the accumulator upper field:
- 000/111 -> 0
- 001/010 -> +M
- 011 -> +2M
- 100 -> -2M
- 101/110 -> -M
It SHALL then arithmetic-shift the accumulator right by 2.
REQ-015 SHALL size the accumulator and adder so that ±2M never overflows (at least WIDTH+3 bits for the upper field).
REQ-016 SHALL produce an exact prod, with no truncation error, for every operand pair in both modes.
REQ-017 SHALL, after the ITER-th iteration, go to DONE; in DONE, prod <= final product, done=1 for exactly one cycle, then the block returns to IDLE.
REQ-018 SHALL meet the following latency: with start sampled at edge k, done=1 and the new prod are visible after edge k+ITER+1 (WIDTH=16: 10 cycles).
REQ-019 SHALL drive busy=1 from edge k through the DONE cycle inclusive, and busy=0 in IDLE.
REQ-020 SHALL ignore start while in CALC or DONE; no queuing, and the current operation is unaffected.
REQ-021 SHALL NOT let changes on A, B or signed_mode after capture affect the running operation.
REQ-022 SHALL hold prod unchanged from DONE until the next DONE; starting a new operation SHALL NOT clear prod.
REQ-023 SHALL accept a start asserted in the first IDLE cycle after DONE, giving back-to-back throughput of one result per ITER+2 cycles.
REQ-024 SHALL never assert done without a preceding accepted start.

Reset
REQ-025 SHALL, while rst=1 (immediately, independent of clk): state=IDLE, prod=0, busy=0, done=0, accumulator=0, counter=0.
REQ-026 SHALL abort any operation in progress when rst is asserted mid-operation: no done pulse is produced and prod reads 0.
REQ-027 SHALL accept start at the first rising edge after rst deasserts.

Verification
REQ-028 SHALL cover: WIDTH=16, signed_mode=1, A=0x8000, B=0x8000 -> prod=0x40000000, done exactly 10 cycles after start, one cycle wide.
REQ-029 SHALL cover: WIDTH=16, signed_mode=0, A=0xFFFF, B=0xFFFF -> prod=0xFFFE0001; the same operands with signed_mode=1 -> prod=0x00000001.
REQ-030 SHALL cover: WIDTH=16, signed_mode=1, A=0x0007, B=0xFFFD (-3) -> prod=0xFFFFFFEB (-21); start re-pulsed and A/B changed during busy -> result unchanged, no second done.
REQ-031 SHALL cover: rst asserted 4 cycles into CALC -> busy=0, done=0 and prod=0 without waiting for a clock edge; the next start with A=3, B=5 -> prod=15.
REQ-032 SHALL cover: back-to-back starts with WIDTH=8 and WIDTH=32 against a reference multiply, at least 10k random operands per mode plus 0, 1, -1, max and min corners -> all prod match, and done count equals start-accept count.

Source files
------------

// File: rtl/booth_radix4_multiplier.sv
// Sequential radix-4 Booth multiplier: one recoded digit per cycle, WIDTH/2+1 cycles,
// signed or unsigned operands selected per operation.
module booth_radix4_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 busy,
    output logic                 done
);

    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
        $error("booth_radix4_multiplier: WIDTH must be even and >= 4");
    end

    localparam int EW   = WIDTH + 2;
    localparam int UW   = WIDTH + 4;
    localparam int ITER = WIDTH / 2 + 1;
    localparam int CW   = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  w_busy;

    logic [EW-1:0]         r_m;
    logic [EW-1:0]         r_q;
    logic [UW-1:0]         r_u;
    logic                  r_prev;
    logic [CW-1:0]         r_cnt;
    logic [2*WIDTH-1:0]    r_prod;
    logic                  r_done;

    logic [2:0]            w_sel;
    logic [UW-1:0]         w_m_ext;
    logic [UW-1:0]         w_addend;
    logic [UW-1:0]         w_sum;
    logic signed [UW+EW-1:0] w_cat;
    logic signed [UW+EW-1:0] w_shifted;
    logic [2*WIDTH-1:0]    w_prod;

    // Upper field carries two guard bits beyond the +-2M range so partial sums never wrap.
    assign w_sel   = {r_q[1:0], r_prev};
    assign w_m_ext = {{2{r_m[EW-1]}}, r_m};

    always_comb begin
        w_addend = '0;
        case (w_sel)
            3'b001, 3'b010: w_addend = w_m_ext;
            3'b011:         w_addend = w_m_ext << 1;
            3'b100:         w_addend = -(w_m_ext << 1);
            3'b101, 3'b110: w_addend = -w_m_ext;
            default:        w_addend = '0;
        endcase
    end

    assign w_sum     = r_u + w_addend;
    assign w_cat     = {w_sum, r_q};
    assign w_shifted = w_cat >>> 2;
    assign w_prod    = {r_u[WIDTH-3:0], r_q};

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_CALC;
            end
            S_CALC: begin
                w_busy = 1'b1;
                if (r_cnt == LAST) w_next = S_DONE;
            end
            S_DONE: begin
                w_busy = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m    <= '0;
            r_q    <= '0;
            r_u    <= '0;
            r_prev <= 1'b0;
            r_cnt  <= '0;
            r_prod <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_m    <= signed_mode ? {{2{B[WIDTH-1]}}, B} : {2'b00, B};
                        r_q    <= signed_mode ? {{2{A[WIDTH-1]}}, A} : {2'b00, A};
                        r_u    <= '0;
                        r_prev <= 1'b0;
                        r_cnt  <= '0;
                    end
                end
                S_CALC: begin
                    r_u    <= w_shifted[UW+EW-1:EW];
                    r_q    <= w_shifted[EW-1:0];
                    r_prev <= r_q[1];
                    r_cnt  <= r_cnt + CW'(1);
                end
                S_DONE: r_prod <= w_prod;
                default: ;
            endcase
        end
    end

    assign prod = r_prod;
    assign busy = w_busy;
    assign done = r_done;

endmodule
